// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: the ALU writeback path always wins; LSU
// results wait in a small FIFO and drain whenever the ALU leaves the port idle.
module wb_write_arbiter #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        lsu_ready,
  input  logic [4:0]  query_reg_1,
  input  logic [4:0]  query_reg_2,
  output logic        pending_1,
  output logic        pending_2,
  output logic        reg_write,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data
);

  logic [PTR_W-1:0]       rptr, wptr;
  logic [PTR_W:0]         count;
  logic [DEPTH-1:0]       ent_vld;
  logic [DEPTH-1:0][4:0]  ent_rd;
  logic [DEPTH-1:0][31:0] ent_data;
  logic alu_eff, accept, push, pop;
  logic hit_1, hit_2;

  assign lsu_ready = !reset && (count != (PTR_W+1)'(DEPTH));
  assign accept    = lsu_valid && lsu_ready;
  // rd=0 results complete the handshake but are never stored
  assign push      = accept && (lsu_rd != 5'd0);
  assign alu_eff   = alu_valid && (alu_rd != 5'd0);
  // uses the pre-edge count, so an entry pushed this edge cannot pop this edge
  assign pop       = !alu_eff && (count != '0);

  always_comb begin
    hit_1 = 1'b0;
    hit_2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (ent_rd[i] == query_reg_1)) hit_1 = 1'b1;
      if (ent_vld[i] && (ent_rd[i] == query_reg_2)) hit_2 = 1'b1;
    end
  end

  assign pending_1 = (query_reg_1 != 5'd0) &&
                     (hit_1 || (accept && (lsu_rd == query_reg_1)));
  assign pending_2 = (query_reg_2 != 5'd0) &&
                     (hit_2 || (accept && (lsu_rd == query_reg_2)));

  // payload storage needs no reset; ent_vld qualifies every read of it
  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd[wptr]   <= lsu_rd;
      ent_data[wptr] <= lsu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr       <= '0;
      wptr       <= '0;
      count      <= '0;
      ent_vld    <= '0;
      reg_write  <= 1'b0;
      write_reg  <= 5'd0;
      write_data <= 32'd0;
    end else begin
      // push and pop never target the same slot: that needs count 0 or DEPTH
      if (pop) begin
        ent_vld[rptr] <= 1'b0;
        rptr          <= rptr + 1'b1;
      end
      if (push) begin
        ent_vld[wptr] <= 1'b1;
        wptr          <= wptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (alu_eff) begin
        reg_write  <= 1'b1;
        write_reg  <= alu_rd;
        write_data <= alu_data;
      end else if (pop) begin
        reg_write  <= 1'b1;
        write_reg  <= ent_rd[rptr];
        write_data <= ent_data[rptr];
      end else begin
        reg_write  <= 1'b0;
      end
    end
  end

endmodule
